// File: rtl/la_playback_controller.sv
// la_playback_controller
// Replays a logic-analyzer capture from a circular single-port sample RAM
// (1-cycle read latency) onto a valid/ready sample stream, oldest sample first.
// Optional feature: define LA_PLAYBACK_LOOP_EN to add the 'loop' port, which
// repeats the latched pass until stop or rst.
module la_playback_controller #(
    parameter int SAMPLE_DEPTH = 4096,
    parameter int SAMPLE_WIDTH = 7,
    localparam int AW          = $clog2(SAMPLE_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [AW-1:0]           base_addr,
    input  logic [AW:0]             length,
`ifdef LA_PLAYBACK_LOOP_EN
    input  logic                    loop,
`endif
    output logic [AW-1:0]           mem_addr,
    input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
    output logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LATCH,
        PRESENT
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(SAMPLE_DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           mem_addr_q, mem_addr_d;
    logic [AW-1:0]           base_q, base_d;
    logic [AW:0]             length_q, length_d;
    logic [AW:0]             idx_q, idx_d;
    logic [AW:0]             idx_next;
    logic [SAMPLE_WIDTH-1:0] sample_data_q, sample_data_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    len_ok;
    logic                    loop_latched;
`ifdef LA_PLAYBACK_LOOP_EN
    logic                    loop_q, loop_d;
`endif

    assign idx_next = idx_q + ONE_L;
    assign len_ok   = (length != '0) && (length <= DEPTH_L);
`ifdef LA_PLAYBACK_LOOP_EN
    assign loop_latched = loop_q;
`else
    assign loop_latched = 1'b0;
`endif

    // Next-state logic: walk IDLE -> ISSUE -> LATCH -> PRESENT, with stop overriding everything but reset.
    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        base_d         = base_q;
        length_d       = length_q;
        idx_d          = idx_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
`ifdef LA_PLAYBACK_LOOP_EN
        loop_d         = loop_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (len_ok) begin
                        base_d     = base_addr;
                        length_d   = length;
                        idx_d      = '0;
                        mem_addr_d = base_addr;
`ifdef LA_PLAYBACK_LOOP_EN
                        loop_d     = loop;
`endif
                        state_d    = ISSUE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = LATCH;
            end
            LATCH: begin
                sample_data_d  = mem_rdata;
                sample_valid_d = 1'b1;
                state_d        = PRESENT;
            end
            PRESENT: begin
                if (sample_valid_q && sample_ready) begin
                    sample_valid_d = 1'b0;
                    idx_d          = idx_next;
                    if (idx_next == length_q) begin
                        done_d = 1'b1;
                        if (loop_latched) begin
                            idx_d      = '0;
                            mem_addr_d = base_q;
                            state_d    = ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        mem_addr_d = base_q + idx_next[AW-1:0];
                        state_d    = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (stop && (state_q != IDLE)) begin
            state_d        = IDLE;
            sample_valid_d = 1'b0;
            done_d         = 1'b0;
            idx_d          = idx_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_addr_q     <= '0;
            base_q         <= '0;
            length_q       <= '0;
            idx_q          <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef LA_PLAYBACK_LOOP_EN
            loop_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            base_q         <= base_d;
            length_q       <= length_d;
            idx_q          <= idx_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef LA_PLAYBACK_LOOP_EN
            loop_q         <= loop_d;
`endif
        end
    end

    assign mem_addr     = mem_addr_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
